// File: rtl/multi_rst_seq_ctl_if.sv
// ---------------------------------------------------------------------------
// multi_rst_seq_ctl_if
// Groups the per-channel control, request and status signals of the
// multi-channel reset sequencer.
//   rst_ctl_reg : 32-bit control word per channel (EN, MODE, POL, CHAIN, PW, DLY)
//   rst_req     : per-channel reset request
//   rst_out     : per-channel generated reset
//   rst_busy    : channel sequence in progress
//   rst_done    : one-cycle completion pulse
// master = register block side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface multi_rst_seq_ctl_if #(
  parameter int NUM_CH = 4
);
  logic [32*NUM_CH-1:0] rst_ctl_reg;
  logic [NUM_CH-1:0]    rst_req;
  logic [NUM_CH-1:0]    rst_out;
  logic [NUM_CH-1:0]    rst_busy;
  logic [NUM_CH-1:0]    rst_done;

  modport master (
    output rst_ctl_reg,
    output rst_req,
    input  rst_out,
    input  rst_busy,
    input  rst_done
  );

  modport slave (
    input  rst_ctl_reg,
    input  rst_req,
    output rst_out,
    output rst_busy,
    output rst_done
  );
endinterface

// File: rtl/multi_rst_seq_ctl.sv
// ---------------------------------------------------------------------------
// multi_rst_seq_ctl
// NUM_CH independent reset sequencers. Each channel runs IDLE -> ASSERT ->
// (DELAY) -> IDLE, in pulse or level mode, with an optional release delay and
// an optional chain hold on the previous channel. All outputs are registered.
// Ports:
//   CRCU_CLK : clock, rising edge
//   CRCU_RST : synchronous active-high reset
//   bus      : slave side of multi_rst_seq_ctl_if (control words, requests,
//              rst_out / rst_busy / rst_done)
// ---------------------------------------------------------------------------
module multi_rst_seq_ctl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic               CRCU_CLK,
  input  logic               CRCU_RST,
  multi_rst_seq_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_DELAY  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_t            r_state [NUM_CH];
  logic [CNT_W-1:0]  r_cnt   [NUM_CH];
  logic [CNT_W-1:0]  r_dly   [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_pol;
  logic [NUM_CH-1:0] r_chain;
  logic [NUM_CH-1:0] r_out;
  logic [NUM_CH-1:0] r_busy;
  logic [NUM_CH-1:0] r_done;

  state_t            w_nxt_state [NUM_CH];
  logic [CNT_W-1:0]  w_nxt_cnt   [NUM_CH];
  logic [CNT_W-1:0]  w_nxt_dly   [NUM_CH];
  logic [NUM_CH-1:0] w_nxt_mode;
  logic [NUM_CH-1:0] w_nxt_pol;
  logic [NUM_CH-1:0] w_nxt_chain;
  logic [NUM_CH-1:0] w_nxt_out;
  logic [NUM_CH-1:0] w_nxt_busy;
  logic [NUM_CH-1:0] w_nxt_done;

  // Reserved control-word bits are intentionally ignored.
  logic w_unused_ctl;
  assign w_unused_ctl = ^bus.rst_ctl_reg;

  // Next-state, counter, latch and output decode for every channel.
  always_comb begin : p_next
    logic             w_prev_idle;
    logic             w_hold;
    logic             w_en;
    logic             w_req;
    logic [CNT_W-1:0] w_pw1;
    w_prev_idle = 1'b1;
    w_hold      = 1'b0;
    w_en        = 1'b0;
    w_req       = 1'b0;
    w_pw1       = CNT_ONE;
    w_nxt_mode  = r_mode;
    w_nxt_pol   = r_pol;
    w_nxt_chain = r_chain;
    w_nxt_out   = {NUM_CH{1'b0}};
    w_nxt_busy  = {NUM_CH{1'b0}};
    w_nxt_done  = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_nxt_state[i] = r_state[i];
      w_nxt_cnt[i]   = r_cnt[i];
      w_nxt_dly[i]   = r_dly[i];
      w_en  = bus.rst_ctl_reg[32*i];
      w_req = bus.rst_req[i];
      // PW of zero behaves as a single-cycle pulse.
      if (bus.rst_ctl_reg[32*i+8 +: CNT_W] == CNT_ZERO) begin
        w_pw1 = CNT_ONE;
      end else begin
        w_pw1 = bus.rst_ctl_reg[32*i+8 +: CNT_W];
      end
      // Chain hold looks at the previous channel's post-edge state so that a
      // chained pair finishes on the same edge.
      w_hold = (i != 32'sd0) && r_chain[i] && !w_prev_idle;

      if (!w_en) begin
        w_nxt_state[i] = ST_IDLE;
        w_nxt_cnt[i]   = CNT_ZERO;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_req) begin
              w_nxt_state[i] = ST_ASSERT;
              w_nxt_cnt[i]   = w_pw1;
              w_nxt_mode[i]  = bus.rst_ctl_reg[32*i+1];
              w_nxt_pol[i]   = bus.rst_ctl_reg[32*i+2];
              w_nxt_chain[i] = bus.rst_ctl_reg[32*i+3];
              w_nxt_dly[i]   = bus.rst_ctl_reg[32*i+16 +: CNT_W];
              w_nxt_out[i]   = bus.rst_ctl_reg[32*i+2];
              w_nxt_busy[i]  = 1'b1;
            end else begin
              w_nxt_out[i] = ~r_pol[i];
            end
          end
          ST_ASSERT: begin
            if (r_mode[i] ? (r_cnt[i] > CNT_ONE) : w_req) begin
              if (r_mode[i]) begin
                w_nxt_cnt[i] = r_cnt[i] - CNT_ONE;
              end else begin
                w_nxt_cnt[i] = r_cnt[i];
              end
              w_nxt_out[i]  = r_pol[i];
              w_nxt_busy[i] = 1'b1;
            end else if ((r_dly[i] != CNT_ZERO) || w_hold) begin
              w_nxt_state[i] = ST_DELAY;
              w_nxt_cnt[i]   = r_dly[i];
              w_nxt_out[i]   = r_pol[i];
              w_nxt_busy[i]  = 1'b1;
            end else begin
              w_nxt_state[i] = ST_IDLE;
              w_nxt_cnt[i]   = CNT_ZERO;
              w_nxt_out[i]   = ~r_pol[i];
              w_nxt_done[i]  = 1'b1;
            end
          end
          ST_DELAY: begin
            if (!r_mode[i] && w_req) begin
              // Level re-request discards the remaining delay.
              w_nxt_state[i] = ST_ASSERT;
              w_nxt_cnt[i]   = CNT_ZERO;
              w_nxt_out[i]   = r_pol[i];
              w_nxt_busy[i]  = 1'b1;
            end else if (r_cnt[i] > CNT_ONE) begin
              w_nxt_cnt[i]  = r_cnt[i] - CNT_ONE;
              w_nxt_out[i]  = r_pol[i];
              w_nxt_busy[i] = 1'b1;
            end else if (w_hold) begin
              w_nxt_cnt[i]  = CNT_ZERO;
              w_nxt_out[i]  = r_pol[i];
              w_nxt_busy[i] = 1'b1;
            end else begin
              w_nxt_state[i] = ST_IDLE;
              w_nxt_cnt[i]   = CNT_ZERO;
              w_nxt_out[i]   = ~r_pol[i];
              w_nxt_done[i]  = 1'b1;
            end
          end
          default: begin
            w_nxt_state[i] = ST_IDLE;
            w_nxt_cnt[i]   = CNT_ZERO;
          end
        endcase
      end
      w_prev_idle = (w_nxt_state[i] == ST_IDLE);
    end
  end

  // State, counter, latched-field and output registers.
  always_ff @(posedge CRCU_CLK) begin
    if (CRCU_RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= CNT_ZERO;
        r_dly[i]   <= CNT_ZERO;
      end
      r_mode  <= {NUM_CH{1'b0}};
      r_pol   <= {NUM_CH{1'b0}};
      r_chain <= {NUM_CH{1'b0}};
      r_out   <= {NUM_CH{1'b0}};
      r_busy  <= {NUM_CH{1'b0}};
      r_done  <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_nxt_state[i];
        r_cnt[i]   <= w_nxt_cnt[i];
        r_dly[i]   <= w_nxt_dly[i];
      end
      r_mode  <= w_nxt_mode;
      r_pol   <= w_nxt_pol;
      r_chain <= w_nxt_chain;
      r_out   <= w_nxt_out;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  assign bus.rst_out  = r_out;
  assign bus.rst_busy = r_busy;
  assign bus.rst_done = r_done;

endmodule

// File: tb/tb_multi_rst_seq_ctl.sv
// ---------------------------------------------------------------------------
// tb_multi_rst_seq_ctl
// Directed scenarios plus randomized traffic. A reference model tracks each
// channel as "active until absolute edge m_rel" and pushes the expected
// outputs for every edge into a scoreboard queue; a monitor pops and compares
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_multi_rst_seq_ctl;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef logic [3*NUM_CH-1:0] exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0]       ctl [NUM_CH];
  logic [NUM_CH-1:0] req;

  always #5 clk = ~clk;

  multi_rst_seq_ctl_if #(.NUM_CH(NUM_CH)) bus ();

  multi_rst_seq_ctl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .CRCU_CLK(clk),
    .CRCU_RST(rst),
    .bus     (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  bit m_act   [NUM_CH];
  int m_rel   [NUM_CH];
  bit m_mode  [NUM_CH];
  bit m_pol   [NUM_CH];
  bit m_chain [NUM_CH];
  int m_dly   [NUM_CH];
  int edge_n = 0;

  function automatic logic [31:0] mkw(bit en, bit mode, bit pol, bit chain, int pw, int dly);
    return {8'd0, 8'(dly), 8'(pw), 4'd0, chain, pol, mode, en};
  endfunction

  // Expected outputs after the coming edge, given the inputs now applied.
  function automatic exp_t model_step();
    logic [NUM_CH-1:0] o, b, d;
    bit prev_idle;
    int p;
    o = '0; b = '0; d = '0;
    prev_idle = 1'b1;
    edge_n++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_act[i] = 1'b0; m_pol[i] = 1'b0; m_mode[i] = 1'b0;
        m_chain[i] = 1'b0; m_dly[i] = 0; m_rel[i] = 0;
      end else begin
        if (!ctl[i][0]) begin
          m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
          if (req[i]) begin
            m_act[i]   = 1'b1;
            m_mode[i]  = ctl[i][1];
            m_pol[i]   = ctl[i][2];
            m_chain[i] = ctl[i][3];
            m_dly[i]   = int'(ctl[i][23:16]);
            p          = int'(ctl[i][15:8]);
            if (p == 0) p = 1;
            // pulse: PW active cycles; level: held for at least this cycle
            m_rel[i]   = edge_n + (m_mode[i] ? p : 1) + m_dly[i];
          end
        end else begin
          if (!m_mode[i] && req[i]) m_rel[i] = edge_n + 1 + m_dly[i];
          if (edge_n >= m_rel[i] && (i == 0 || !m_chain[i] || prev_idle)) begin
            m_act[i] = 1'b0;
            d[i]     = 1'b1;
          end
        end
        b[i] = m_act[i];
        o[i] = m_act[i] ? m_pol[i] : (ctl[i][0] ? ~m_pol[i] : 1'b0);
      end
      prev_idle = !m_act[i];
    end
    return {o, b, d};
  endfunction

  task automatic tick();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) bus.rst_ctl_reg[32*i +: 32] = ctl[i];
    bus.rst_req = req;
    e = model_step();
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if ({bus.rst_out, bus.rst_busy, bus.rst_done} !== mon_e) begin
        n_err++;
        $display("FAIL outputs t=%0t out/busy/done got %h/%h/%h expected %h/%h/%h", $time,
                 bus.rst_out, bus.rst_busy, bus.rst_done,
                 mon_e[3*NUM_CH-1 -: NUM_CH], mon_e[2*NUM_CH-1 -: NUM_CH], mon_e[NUM_CH-1:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NUM_CH; i++) ctl[i] = mkw(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // pulse PW=5, active-high, no delay
    ctl[0] = mkw(1'b1, 1'b1, 1'b1, 1'b0, 5, 0);
    req[0] = 1'b1; tick(); req[0] = 1'b0;
    repeat (8) tick();

    // level mode, active-low, DLY=3; then a re-request inside DELAY
    ctl[1] = mkw(1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
    req[1] = 1'b1; repeat (4) tick(); req[1] = 1'b0;
    repeat (6) tick();
    req[1] = 1'b1; repeat (4) tick(); req[1] = 1'b0; tick();
    req[1] = 1'b1; tick(); req[1] = 1'b0;
    repeat (6) tick();

    // chained pair requested together
    ctl[0] = mkw(1'b1, 1'b1, 1'b1, 1'b0, 10, 0);
    ctl[1] = mkw(1'b1, 1'b1, 1'b1, 1'b1, 2, 0);
    req[1:0] = 2'b11; tick(); req = '0;
    repeat (14) tick();

    // EN dropped two cycles into a PW=8 pulse
    ctl[2] = mkw(1'b1, 1'b1, 1'b1, 1'b0, 8, 0);
    req[2] = 1'b1; tick(); req[2] = 1'b0;
    repeat (2) tick();
    ctl[2][0] = 1'b0; repeat (3) tick();
    ctl[2][0] = 1'b1; repeat (2) tick();

    // reset during DELAY, then PW=0, then mid-sequence PW/DLY write
    for (int i = 0; i < NUM_CH; i++) ctl[i] = mkw(1'b1, 1'b1, (i % 2) == 1, 1'b0, 1, 6);
    req = '1; tick(); req = '0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < NUM_CH; i++) ctl[i] = mkw(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    req = '1; tick(); req = '0;
    repeat (3) tick();
    ctl[0] = mkw(1'b1, 1'b1, 1'b1, 1'b0, 4, 2);
    req[0] = 1'b1; tick(); req[0] = 1'b0; tick();
    ctl[0] = mkw(1'b1, 1'b1, 1'b0, 1'b0, 9, 9);
    repeat (10) tick();

    // randomized traffic
    repeat (3000) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 15) == 0)
          ctl[i] = mkw($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
        req[i] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    req = '0;
    repeat (2) tick();

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain scoreboard entries left %0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_rst_seq_ctl.md
MULTI_RST_SEQ_CTL -- requirements
Module: multi_rst_seq_ctl

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent reset channels (legal range 1-16).
REQ-002 Parameter CNT_W, default 8, width of the per-channel pulse-width and release-delay counters (legal range 1-8).
REQ-003 CRCU_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 CRCU_RST  input  1  reset; synchronous, active-high.
REQ-005 rst_ctl_reg  input  32*NUM_CH  one 32-bit control word per channel; channel i occupies bits [32*i+31:32*i].
REQ-006 rst_req  input  NUM_CH  per-channel reset request from the APB register block.
REQ-007 rst_out  output  NUM_CH  per-channel generated reset.
REQ-008 rst_busy  output  NUM_CH  high while the channel is not IDLE.
REQ-009 rst_done  output  NUM_CH  one-cycle pulse marking completion of the channel's reset sequence.

Function
REQ-010 Each control word has these fields: bit0 EN; bit1 MODE (0 = level, 1 = pulse); bit2 POL (1 = active-high, 0 = active-low); bit3 CHAIN; bits[8+CNT_W-1:8] PW (pulse width); bits[16+CNT_W-1:16] DLY (release delay); all other bits are ignored.
REQ-011 Each channel has an independent FSM with the states IDLE, ASSERT and DELAY; all outputs are registered.
REQ-012 IDLE->ASSERT: the transition occurs at edge N when EN=1 and rst_req=1. From cycle N+1, rst_out is at its active level, rst_busy=1, and MODE, POL, PW and DLY are latched.
REQ-013 Latched fields stay fixed for the whole sequence; later writes to MODE, POL, PW, DLY or CHAIN take effect only on the next IDLE->ASSERT transition.
REQ-014 Pulse mode: ASSERT lasts max(PW,1) cycles, and rst_req is ignored while in ASSERT or DELAY (no retrigger).
REQ-015 Level mode: the channel stays in ASSERT while rst_req=1 and leaves ASSERT on the first edge that samples rst_req=0.
REQ-016 On leaving ASSERT, the channel enters DELAY if DLY>0 or if a chain hold applies; otherwise it enters IDLE directly.
REQ-017 DELAY: rst_out remains active, and the channel counts down DLY cycles before moving to IDLE.
REQ-018 Level mode, rst_req=1 sampled in DELAY: the channel returns to ASSERT and the delay counter is discarded.
REQ-019 Total active width of rst_out: max(PW,1)+DLY cycles in pulse mode; (request-high cycles)+DLY cycles in level mode, excluding chain hold.
REQ-020 CHAIN=1 for channel i>0: after its DLY count expires, channel i stays in DELAY until channel i-1 is in IDLE; it releases on the first edge at which that condition holds.
REQ-021 CHAIN is ignored for channel 0.
REQ-022 rst_out inactive level: ~POL (latched) while EN=1; 1'b0 while EN=0.
REQ-023 EN dropped mid-sequence: on the next edge the channel goes to IDLE, rst_out=0 and rst_busy=0, and no rst_done is issued.
REQ-024 rst_done: high for exactly one cycle, in the same cycle that rst_out first returns inactive after a completed sequence.
REQ-025 Counters never wrap: they load at state entry and decrement to 0.
REQ-026 PW=0 is treated as PW=1; DLY=0 means no delay cycles.
REQ-027 rst_req=1 in the same cycle that EN rises is accepted.
REQ-028 Channels do not interact except through CHAIN.

Reset
REQ-029 While CRCU_RST=1 at a clock edge, every channel shall go to IDLE, all counters shall clear, and latched fields shall clear (POL=0), giving rst_out=0, rst_busy=0 and rst_done=0 in the following cycle.
REQ-030 CRCU_RST asserted mid-sequence shall abort the sequence without issuing rst_done.
REQ-031 After CRCU_RST is released, an EN=1 channel with POL=0 shall drive rst_out=1 (inactive) from the first post-reset edge.

Verification
REQ-032 Ch0 EN=1, MODE=1, POL=1, PW=5, DLY=0; 1-cycle rst_req at edge 10 -> rst_out=1 in cycles 11-15; rst_done=1 in cycle 16 only; rst_busy=1 in cycles 11-15.
REQ-033 Ch1 MODE=0, POL=0, DLY=3; rst_req high for 4 cycles from edge 20 -> rst_out=0 in cycles 21-27; rst_done in cycle 28; re-raise rst_req at cycle 25 -> returns to ASSERT with no rst_done.
REQ-034 Ch0 PW=10; Ch1 CHAIN=1, PW=2, DLY=0; both requested at the same edge -> Ch1 stays asserted until Ch0 is IDLE; both rst_done pulses occur in the same cycle.
REQ-035 EN cleared 2 cycles into a PW=8 pulse -> rst_out=0 and rst_busy=0 on the next edge; no rst_done is issued.
REQ-036 CRCU_RST pulsed during DELAY on all channels -> all outputs are 0 the next cycle; PW=0 then behaves as a 1-cycle pulse, and a PW/DLY write mid-sequence does not alter the current sequence.
